inst_sram_responder: RTL

- Synchronous SRAM responder that serves the instruction-SRAM initiator port driven by the fetch stage: en, we, addr, wdata in; rdata out.
- One-cycle read latency with hold-on-idle, byte-lane writes, an address window check with a sticky error, and a side-band word-load port for program preload.
- Sits at the SoC top between the core's inst SRAM interface and the simulation/FPGA memory image.

---
 rtl/inst_sram_responder_pkg.sv | 25 ++
 rtl/inst_sram_responder_if.sv | 27 ++
 rtl/inst_sram_byte_array.sv | 46 ++++
 rtl/inst_sram_responder.sv | 138 +++++++++++++
 4 files changed

// File: rtl/inst_sram_responder_pkg.sv
// Shared constants and types for the instruction-SRAM responder.
// Holds the default base address and depth used by the SoC memory image.
// Also holds the read-data source selector and the address-window helper.
package inst_sram_responder_pkg;

  // Byte address that maps to word 0 of the instruction SRAM.
  localparam logic [31:0] INST_SRAM_BASE       = 32'h1c000000;
  // log2 of the number of 32-bit words (4096 words = 16 KiB).
  localparam int unsigned INST_SRAM_DEPTH_LOG2 = 32'd12;

  // Selects where sram_rdata comes from.
  // rdata is driven from registers only, so it holds while the fetch stage stalls.
  typedef enum logic [1:0] {
    RSEL_RESET = 2'd0,  // nothing served since reset: present the reset value
    RSEL_ZERO  = 2'd1,  // last access fell outside the window
    RSEL_MEM   = 2'd2   // last access was served by the storage array
  } rsel_t;

  // True when a byte offset from the base lands inside a 2^(depth_log2+2)-byte window.
  // Offsets below the base have wrapped to large values and fail this test.
  function automatic logic in_window(input logic [31:0] off, input int unsigned depth_log2);
    in_window = ((off >> (depth_log2 + 32'd2)) == 32'd0);
  endfunction

endpackage

// File: rtl/inst_sram_responder_if.sv
// Instruction-SRAM initiator bus between the fetch stage and the responder.
// The master modport is the fetch stage; the slave modport is the responder.
interface inst_sram_responder_if;

  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (
    output sram_en,
    output sram_we,
    output sram_addr,
    output sram_wdata,
    input  sram_rdata
  );

  modport slave (
    input  sram_en,
    input  sram_we,
    input  sram_addr,
    input  sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/inst_sram_byte_array.sv
// Storage array for the instruction SRAM.
// It has one read-first access port with byte write enables and one full-word load port.
// The load port wins any collision.
// The array has no reset and keeps a plain block-RAM coding pattern.
// Window checks, error capture and the output select all live in the parent module.
module inst_sram_byte_array
  import inst_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = INST_SRAM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  acc_en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [31:0]           wdata,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_idx,
  input  logic [31:0]           ld_data,
  output logic [31:0]           q
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

  logic [31:0] mem_r [DEPTH];
  logic [31:0] q_r;

  // Read-first access port plus a priority load port.
  // q only moves on an access, so it holds its value while the bus is idle.
  always_ff @(posedge clk) begin
    if (acc_en) begin
      q_r <= mem_r[idx];
    end
    if (ld_en) begin
      mem_r[ld_idx] <= ld_data;
    end else if (acc_en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign q = q_r;

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction-SRAM responder at the SoC top.
// It serves the fetch stage with one-cycle registered reads and holds rdata while the bus is idle.
// It supports byte-lane writes, a sticky out-of-window error and a word preload port.
// Optional feature macro: INST_SRAM_ACCESS_CNT_EN adds the rd_cnt/wr_cnt access counters.
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = INST_SRAM_BASE,
  parameter int unsigned DEPTH_LOG2  = INST_SRAM_DEPTH_LOG2,
  parameter logic [31:0] RESET_RDATA = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  reset,
  inst_sram_responder_if.slave  bus,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_idx,
  input  logic [31:0]           ld_data,
  output logic                  err,
  output logic [31:0]           err_addr
`ifdef INST_SRAM_ACCESS_CNT_EN
  ,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
`endif
);

  logic [31:0]           off_s;
  logic                  in_win_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  acc_s;
  logic [3:0]            arr_we_s;
  logic [31:0]           arr_q_s;
  logic [31:0]           rdata_s;
  rsel_t                 rsel_r;
  logic                  err_r;
  logic [31:0]           err_addr_r;

  // Word index comes from the wrapped byte offset.
  // Address bits [1:0] never reach the lane selection.
  assign off_s    = bus.sram_addr - BASE_ADDR;
  assign in_win_s = in_window(off_s, DEPTH_LOG2);
  assign idx_s    = off_s[DEPTH_LOG2+1:2];
  assign acc_s    = bus.sram_en & in_win_s;

  // A preload in the same cycle drops any SRAM write. A read still sees the pre-load word.
  always_comb begin
    arr_we_s = 4'h0;
    if (ld_en) begin
      arr_we_s = 4'h0;
    end else begin
      arr_we_s = bus.sram_we;
    end
  end

  inst_sram_byte_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .acc_en  (acc_s),
    .we      (arr_we_s),
    .idx     (idx_s),
    .wdata   (bus.sram_wdata),
    .ld_en   (ld_en),
    .ld_idx  (ld_idx),
    .ld_data (ld_data),
    .q       (arr_q_s)
  );

  // Remember where the last access was answered from. Idle cycles leave this unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsel_r <= RSEL_RESET;
    end else if (bus.sram_en) begin
      rsel_r <= in_win_s ? RSEL_MEM : RSEL_ZERO;
    end
  end

  // Choose rdata among registered sources only.
  // The array word is used only when the array served the last access.
  always_comb begin
    rdata_s = 32'h00000000;
    case (rsel_r)
      RSEL_RESET: rdata_s = RESET_RDATA;
      RSEL_ZERO:  rdata_s = 32'h00000000;
      RSEL_MEM:   rdata_s = arr_q_s;
      default:    rdata_s = 32'h00000000;
    endcase
  end

  assign bus.sram_rdata = rdata_s;

  // Sticky window error. It keeps the address of the first offender until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r      <= 1'b0;
      err_addr_r <= 32'h00000000;
    end else if (bus.sram_en && !in_win_s) begin
      err_r <= 1'b1;
      if (!err_r) begin
        err_addr_r <= bus.sram_addr;
      end
    end
  end

  assign err      = err_r;
  assign err_addr = err_addr_r;

`ifdef INST_SRAM_ACCESS_CNT_EN
  logic        rd_acc_s;
  logic        wr_acc_s;
  logic [31:0] rd_cnt_r;
  logic [31:0] wr_cnt_r;

  assign rd_acc_s = acc_s && (bus.sram_we == 4'h0);
  assign wr_acc_s = acc_s && (bus.sram_we != 4'h0) && !ld_en;

  // Count accepted reads and writes. Both counters wrap freely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_r <= 32'h00000000;
      wr_cnt_r <= 32'h00000000;
    end else begin
      if (rd_acc_s) begin
        rd_cnt_r <= rd_cnt_r + 32'd1;
      end
      if (wr_acc_s) begin
        wr_cnt_r <= wr_cnt_r + 32'd1;
      end
    end
  end

  assign rd_cnt = rd_cnt_r;
  assign wr_cnt = wr_cnt_r;
`else
  // Access counters are not built.
`endif

endmodule
